// File: rtl/axi_lite_stream_writer.sv
// AXI-lite write master: drains a valid/ready stream into consecutive word addresses
// starting at a programmed base, one job per start pulse, with bounded outstanding writes.
module axi_lite_stream_writer #(
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 32,
   parameter int COUNT_WIDTH     = 16,
   parameter int MAX_OUTSTANDING = 4,
   localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [COUNT_WIDTH-1:0] count,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic                   m_aw_valid,
   input  logic                   m_aw_ready,
   output logic [ADDR_WIDTH-1:0]  m_aw_addr,
   output logic                   m_w_valid,
   input  logic                   m_w_ready,
   output logic [DATA_WIDTH-1:0]  m_w_data,
   output logic [STRB_WIDTH-1:0]  m_w_strb,
   input  logic                   m_b_valid,
   output logic                   m_b_ready,
   input  logic [1:0]             m_b_resp
);
   localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_reg, state_next;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic [COUNT_WIDTH-1:0] accepted_reg;
   logic [COUNT_WIDTH-1:0] acked_reg;
   logic [OUT_WIDTH-1:0]   outstanding_reg;
   logic [ADDR_WIDTH-1:0]  ptr_reg;
   logic [ADDR_WIDTH-1:0]  addr_reg;
   logic [DATA_WIDTH-1:0]  data_reg;
   logic                   aw_pend_reg;
   logic                   w_pend_reg;
   logic                   error_reg;
   logic                   done_reg;

   logic hold_free;
   logic s_fire;
   logic b_take;

   // The hold entry can be refilled in the same cycle its last handshake completes.
   assign hold_free = (!aw_pend_reg || m_aw_ready) && (!w_pend_reg || m_w_ready);
   assign s_fire    = s_valid && s_ready;
   // B responses are only counted against writes actually issued in a live job.
   assign b_take    = m_b_valid && (state_reg != IDLE) && (acked_reg < accepted_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accepted_reg == count_reg) state_next = DRAIN;
         DRAIN:   if (acked_reg == count_reg) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_reg != IDLE);
      s_ready = (state_reg == RUN) && (accepted_reg < count_reg) &&
                (outstanding_reg < OUT_WIDTH'(MAX_OUTSTANDING)) && hold_free;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg       <= '0;
         accepted_reg    <= '0;
         acked_reg       <= '0;
         outstanding_reg <= '0;
         ptr_reg         <= '0;
         addr_reg        <= '0;
         data_reg        <= '0;
         aw_pend_reg     <= 1'b0;
         w_pend_reg      <= 1'b0;
         error_reg       <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg <= (state_reg == DRAIN) && (state_next == IDLE);

         if ((state_reg == IDLE) && start) begin
            count_reg       <= count;
            ptr_reg         <= base_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            accepted_reg    <= '0;
            acked_reg       <= '0;
            outstanding_reg <= '0;
            error_reg       <= 1'b0;
         end

         if (s_fire) begin
            accepted_reg <= accepted_reg + COUNT_WIDTH'(1);
            ptr_reg      <= ptr_reg + ADDR_WIDTH'(STRB_WIDTH);
            addr_reg     <= ptr_reg;
            data_reg     <= s_data;
         end

         if (b_take) begin
            acked_reg <= acked_reg + COUNT_WIDTH'(1);
            if (m_b_resp != 2'b00) error_reg <= 1'b1;
         end

         case ({s_fire, b_take})
            2'b10:   outstanding_reg <= outstanding_reg + OUT_WIDTH'(1);
            2'b01:   outstanding_reg <= outstanding_reg - OUT_WIDTH'(1);
            default: outstanding_reg <= outstanding_reg;
         endcase

         if (s_fire)          aw_pend_reg <= 1'b1;
         else if (m_aw_ready) aw_pend_reg <= 1'b0;

         if (s_fire)         w_pend_reg <= 1'b1;
         else if (m_w_ready) w_pend_reg <= 1'b0;
      end
   end

   assign done       = done_reg;
   assign error      = error_reg;
   assign m_aw_valid = aw_pend_reg;
   assign m_aw_addr  = addr_reg;
   assign m_w_valid  = w_pend_reg;
   assign m_w_data   = data_reg;
   assign m_w_strb   = '1;
   assign m_b_ready  = 1'b1;
endmodule

// File: tb/tb_axi_lite_stream_writer.sv
// Bench for axi_lite_stream_writer: randomized stream/slave timing against a scoreboard
// that derives addresses, data order, outstanding limit and error flag from job parameters.
module tb_axi_lite_stream_writer;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int CW = 16;
   localparam int MO = 4;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] count;
   logic          busy, done, error;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_data;
   logic          m_aw_valid, m_aw_ready;
   logic [AW-1:0] m_aw_addr;
   logic          m_w_valid, m_w_ready;
   logic [DW-1:0] m_w_data;
   logic [SW-1:0] m_w_strb;
   logic          m_b_valid, m_b_ready;
   logic [1:0]    m_b_resp;

   always #5 clk = ~clk;

   axi_lite_stream_writer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .error(error),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
      .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp)
   );

   int tests = 0;
   int fails = 0;

   // Job model: expected words, per-index responses, and progress counters.
   logic [AW-1:0] job_base;
   int            job_n;
   logic          exp_err;
   logic [DW-1:0] words[$];
   logic [1:0]    resp_tab[$];
   logic [AW-1:0] aw_addrs[$];
   int sent, aw_cnt, w_cnt, b_iss, cyc, done_seen, done_cyc, last_b_cyc;
   int first_aw_cyc, last_aw_cyc, first_w_cyc;
   int p_s, p_aw, p_w, p_b, aw_block, b_block;
   logic stray;
   logic prev_awv, prev_awf, prev_wv, prev_wf;
   logic [AW-1:0] prev_awa;
   logic [DW-1:0] prev_wd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic knobs(input int ps, input int paw, input int pw, input int pb,
                        input int awb, input int bb);
      p_s = ps; p_aw = paw; p_w = pw; p_b = pb; aw_block = awb; b_block = bb;
   endtask

   task automatic model_clear();
      sent = 0; aw_cnt = 0; w_cnt = 0; b_iss = 0; cyc = 0;
      done_seen = 0; done_cyc = -1; last_b_cyc = -1;
      first_aw_cyc = -1; last_aw_cyc = -1; first_w_cyc = -1;
      prev_awv = 0; prev_awf = 0; prev_wv = 0; prev_wf = 0;
      prev_awa = '0; prev_wd = '0;
      aw_addrs.delete();
   endtask

   // One clock cycle: drive inputs at negedge, settle, score the handshakes, advance.
   task automatic step();
      logic sf, awf, wf, bf;
      int avail;
      logic [AW-1:0] ea;
      avail = ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) - b_iss;
      s_valid = (sent < job_n) && ($urandom_range(99) < p_s);
      if (sent < job_n) s_data = words[sent];
      else s_data = '0;
      m_aw_ready = (cyc >= aw_block) && ($urandom_range(99) < p_aw);
      m_w_ready  = ($urandom_range(99) < p_w);
      if (stray) begin
         m_b_valid = 1'b1; m_b_resp = 2'b10;
      end else begin
         m_b_valid = (avail > 0) && (cyc >= b_block) && ($urandom_range(99) < p_b);
         m_b_resp  = (avail > 0) ? resp_tab[b_iss] : 2'b00;
      end
      #1;
      sf  = s_valid && s_ready;
      awf = m_aw_valid && m_aw_ready;
      wf  = m_w_valid && m_w_ready;
      bf  = m_b_valid && m_b_ready;
      chk("b_ready_const", m_b_ready, 1'b1);
      chk("s_ready_cap", s_ready && (((sent - b_iss) >= MO) || (sent >= job_n)), 1'b0);
      chk("aw_valid_no_word", m_aw_valid && (aw_cnt >= sent), 1'b0);
      chk("w_valid_no_word", m_w_valid && (w_cnt >= sent), 1'b0);
      if (prev_awv && !prev_awf) begin
         chk("aw_valid_held", m_aw_valid, 1'b1);
         chk("aw_addr_stable", m_aw_addr, prev_awa);
      end
      if (prev_wv && !prev_wf) begin
         chk("w_valid_held", m_w_valid, 1'b1);
         chk("w_data_stable", m_w_data, prev_wd);
      end
      if (awf) begin
         ea = job_base + AW'(aw_cnt * SW);
         chk("aw_addr", m_aw_addr, ea);
         aw_addrs.push_back(m_aw_addr);
         if (aw_cnt == 0) first_aw_cyc = cyc;
         last_aw_cyc = cyc;
         aw_cnt++;
      end
      if (wf) begin
         chk("w_in_range", w_cnt < job_n, 1'b1);
         if (w_cnt < job_n) chk("w_data", m_w_data, words[w_cnt]);
         chk("w_strb", m_w_strb, 8'hFF);
         if (w_cnt == 0) first_w_cyc = cyc;
         w_cnt++;
      end
      prev_awv = m_aw_valid; prev_awf = awf; prev_awa = m_aw_addr;
      prev_wv  = m_w_valid;  prev_wf  = wf;  prev_wd  = m_w_data;
      if (sf) sent++;
      if (bf && !stray) begin
         b_iss++;
         last_b_cyc = cyc;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) begin
         done_seen++;
         done_cyc = cyc;
      end
   endtask

   task automatic start_job(input logic [AW-1:0] base, input int n);
      model_clear();
      job_base = base & ~AW'(SW - 1);
      job_n = n;
      words.delete();
      for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
      while (resp_tab.size() < n) resp_tab.push_back(2'b00);
      exp_err = 1'b0;
      for (int i = 0; i < n; i++) if (resp_tab[i] != 2'b00) exp_err = 1'b1;
      start = 1'b1; base_addr = base; count = CW'(n);
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic finish_job();
      while (done_seen == 0 && cyc < 600) step();
      chk("done_seen", done_seen, 1);
      chk("busy_at_done", busy, 1'b0);
      if (job_n > 0)
         chk("done_after_last_b", (done_cyc - last_b_cyc == 1) || (done_cyc - last_b_cyc == 2), 1'b1);
      chk("error_at_done", error, exp_err);
      chk("aw_total", aw_cnt, job_n);
      chk("w_total", w_cnt, job_n);
      chk("b_total", b_iss, job_n);
      repeat (3) step();
      chk("done_single_pulse", done_seen, 1);
      resp_tab.delete();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
      s_valid = 1'b0; s_data = '0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
      m_b_valid = 1'b0; m_b_resp = 2'b00; stray = 1'b0;
      job_n = 0; job_base = '0; exp_err = 1'b0;
      model_clear();
      knobs(100, 100, 100, 100, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_aw_valid", m_aw_valid, 1'b0);
      chk("rst_w_valid", m_w_valid, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back writes with an always-ready slave.
      knobs(100, 100, 100, 100, 0, 0);
      start_job(32'h0000_1000, 4);
      finish_job();
      chk("t1_first_aw_cyc", first_aw_cyc, 2);
      chk("t1_last_aw_cyc", last_aw_cyc, 5);

      // AW held off while W proceeds.
      knobs(100, 100, 100, 100, 7, 0);
      start_job(32'h0000_2000, 4);
      finish_job();
      chk("t2_w_before_aw", first_w_cyc < first_aw_cyc, 1'b1);
      chk("t2_first_aw_cyc", first_aw_cyc, 7);

      // B withheld: accepts must stop at the outstanding limit.
      knobs(100, 100, 100, 100, 0, 20);
      start_job(32'h0000_3000, 8);
      repeat (14) step();
      chk("t3_accepts_capped", sent, MO);
      chk("t3_s_ready_low", s_ready, 1'b0);
      finish_job();

      // Address wrap past the top of the address space.
      knobs(100, 100, 100, 100, 0, 0);
      start_job(32'hFFFF_FFF8, 2);
      finish_job();
      if (aw_addrs.size() == 2) begin
         chk("t4_addr0", aw_addrs[0], 32'hFFFF_FFF8);
         chk("t4_addr1", aw_addrs[1], 32'h0000_0000);
      end

      // SLVERR on the second B, then a zero-length job clears the flag.
      knobs(100, 100, 100, 100, 0, 0);
      resp_tab.delete();
      resp_tab.push_back(2'b00); resp_tab.push_back(2'b10); resp_tab.push_back(2'b00);
      start_job(32'h0000_4000, 3);
      finish_job();
      chk("t5_error_sticky", error, 1'b1);
      start_job(32'h0000_5000, 0);
      chk("t5_error_cleared", error, 1'b0);
      finish_job();
      chk("t5_zero_done_cyc", done_cyc, 3);
      stray = 1'b1;
      step();
      stray = 1'b0;
      step();
      chk("t5_stray_b_error", error, 1'b0);
      chk("t5_stray_b_busy", busy, 1'b0);
      chk("t5_stray_b_done", done_seen, 1);

      // Reset with writes outstanding, then a fresh job.
      knobs(100, 100, 100, 100, 0, 1000);
      start_job(32'h0000_6000, 8);
      repeat (6) step();
      chk("t6_outstanding_before_rst", (sent - b_iss) >= 2, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_s_ready", s_ready, 1'b0);
      chk("t6_rst_aw_valid", m_aw_valid, 1'b0);
      chk("t6_rst_w_valid", m_w_valid, 1'b0);
      chk("t6_rst_done", done, 1'b0);
      chk("t6_rst_error", error, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_held_busy", busy, 1'b0);
      rst = 1'b0;
      resp_tab.delete();
      model_clear();
      @(negedge clk);
      knobs(100, 100, 100, 100, 0, 0);
      start_job(32'h0000_7000, 5);
      finish_job();

      // Randomized jobs: timing, base alignment, lengths and responses all vary.
      for (int j = 0; j < 20; j++) begin
         int n;
         n = $urandom_range(12);
         resp_tab.delete();
         for (int i = 0; i < n; i++)
            resp_tab.push_back(($urandom_range(9) == 0) ? 2'($urandom_range(3, 2)) : 2'b00);
         knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
               $urandom_range(100, 30), $urandom_range(6), $urandom_range(6));
         start_job($urandom, n);
         finish_job();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
